tlcd_bus_decoder: RTL

//  LCD-side end of the text-LCD bus: a synthesizable HD44780-style responder.

---
 rtl/tlcd_bus_decoder.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/tlcd_bus_decoder.sv
// tlcd_bus_decoder: LCD-side responder for the HD44780-style text-LCD bus.
// Decodes each falling edge of TLCD_E into an instruction or a data write,
// keeps a 2x16 DDRAM shadow, emulates busy time and flags protocol misuse.
module tlcd_bus_decoder #(
    parameter int unsigned BUSY_CYC  = 2,
    parameter int unsigned CLEAR_CYC = 8
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         TLCD_E,
    input  logic         TLCD_RS,
    input  logic         TLCD_RW,
    input  logic [7:0]   TLCD_DATA,
    output logic [127:0] TEXT_UPPER,
    output logic [127:0] TEXT_LOWER,
    output logic [6:0]   CURSOR_ADDR,
    output logic         DISP_ON,
    output logic         FUNC_OK,
    output logic         BUSY,
    output logic         ERR_BUSY,
    output logic         ERR_READ,
    output logic [7:0]   WR_CNT
);

    localparam int unsigned MAX_CYC = (CLEAR_CYC > BUSY_CYC) ? CLEAR_CYC : BUSY_CYC;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int unsigned SHD_W   = 256;

    localparam logic [CNT_W-1:0] BUSY_LOAD  = CNT_W'(BUSY_CYC - 1);
    localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYC - 1);
    localparam logic [SHD_W-1:0] SHD_BLANK  = {32{8'h20}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_BUSY   = 2'd2
    } state_e;

    state_e             state_q,    state_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic               rs_q,       rs_d;
    logic [7:0]         data_q,     data_d;
    logic [6:0]         cursor_q,   cursor_d;
    logic               id_q,       id_d;
    logic               disp_q,     disp_d;
    logic               func_q,     func_d;
    logic               busy_q,     busy_d;
    logic               err_busy_q, err_busy_d;
    logic               err_read_q, err_read_d;
    logic [7:0]         wr_cnt_q,   wr_cnt_d;
    logic [SHD_W-1:0]   shadow_q,   shadow_d;
    logic               e_q;

    logic               strobe_c;
    logic [4:0]         slot_c;
    logic               visible_c;

    // Next DDRAM address: lines are 0x00-0x27 and 0x40-0x67, wrapping into each other.
    function automatic logic [6:0] step_addr(input logic [6:0] addr, input logic inc);
        logic [6:0] nxt;
        nxt = addr;
        if (inc) begin
            if (addr == 7'h27)      nxt = 7'h40;
            else if (addr == 7'h67) nxt = 7'h00;
            else                    nxt = addr + 7'd1;
        end else begin
            if (addr == 7'h40)      nxt = 7'h27;
            else if (addr == 7'h00) nxt = 7'h67;
            else                    nxt = addr - 7'd1;
        end
        return nxt;
    endfunction

    // Strobe on the falling edge of E as seen by the registered copy.
    assign strobe_c  = e_q & ~TLCD_E;

    // Shadow slot of the current address: line bit plus column; only columns 0-15 are kept.
    assign slot_c    = {cursor_q[6], cursor_q[3:0]};
    assign visible_c = (cursor_q[5:4] == 2'b00);

    // Next-state, decode effects and error flags.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rs_d       = rs_q;
        data_d     = data_q;
        cursor_d   = cursor_q;
        id_d       = id_q;
        disp_d     = disp_q;
        func_d     = func_q;
        err_busy_d = err_busy_q;
        err_read_d = err_read_q;
        wr_cnt_d   = wr_cnt_q;
        shadow_d   = shadow_q;

        unique case (state_q)
            S_IDLE: begin
                if (strobe_c) begin
                    if (TLCD_RW) begin
                        err_read_d = 1'b1;
                    end else begin
                        rs_d    = TLCD_RS;
                        data_d  = TLCD_DATA;
                        state_d = S_DECODE;
                    end
                end
            end

            S_DECODE: begin
                if (strobe_c) begin
                    err_busy_d = 1'b1;
                    if (TLCD_RW) err_read_d = 1'b1;
                end
                cnt_d   = BUSY_LOAD;
                state_d = S_BUSY;
                if (rs_q) begin
                    if (visible_c) shadow_d[{~slot_c, 3'b000} +: 8] = data_q;
                    if (wr_cnt_q != 8'hFF) wr_cnt_d = wr_cnt_q + 8'd1;
                    cursor_d = step_addr(cursor_q, id_q);
                end else begin
                    casez (data_q)
                        8'b1???????: cursor_d = data_q[6:0];
                        8'b01??????: ;
                        8'b001?????: func_d = (data_q == 8'h38);
                        8'b0001????: begin
                            if (!data_q[3]) cursor_d = step_addr(cursor_q, data_q[2]);
                        end
                        8'b00001???: disp_d = data_q[2];
                        8'b000001??: id_d = data_q[1];
                        8'b0000001?: begin
                            cursor_d = 7'h00;
                            cnt_d    = CLEAR_LOAD;
                        end
                        8'b00000001: begin
                            shadow_d = SHD_BLANK;
                            cursor_d = 7'h00;
                            id_d     = 1'b1;
                            cnt_d    = CLEAR_LOAD;
                        end
                        default: ;
                    endcase
                end
            end

            S_BUSY: begin
                if (strobe_c) begin
                    err_busy_d = 1'b1;
                    if (TLCD_RW) err_read_d = 1'b1;
                end
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rs_q       <= 1'b0;
            data_q     <= 8'h00;
            cursor_q   <= 7'h00;
            id_q       <= 1'b1;
            disp_q     <= 1'b0;
            func_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_busy_q <= 1'b0;
            err_read_q <= 1'b0;
            wr_cnt_q   <= 8'h00;
            shadow_q   <= SHD_BLANK;
            e_q        <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rs_q       <= rs_d;
            data_q     <= data_d;
            cursor_q   <= cursor_d;
            id_q       <= id_d;
            disp_q     <= disp_d;
            func_q     <= func_d;
            busy_q     <= busy_d;
            err_busy_q <= err_busy_d;
            err_read_q <= err_read_d;
            wr_cnt_q   <= wr_cnt_d;
            shadow_q   <= shadow_d;
            e_q        <= TLCD_E;
        end
    end

    assign TEXT_UPPER  = shadow_q[255:128];
    assign TEXT_LOWER  = shadow_q[127:0];
    assign CURSOR_ADDR = cursor_q;
    assign DISP_ON     = disp_q;
    assign FUNC_OK     = func_q;
    assign BUSY        = busy_q;
    assign ERR_BUSY    = err_busy_q;
    assign ERR_READ    = err_read_q;
    assign WR_CNT      = wr_cnt_q;

endmodule
